// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
// Executes MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring shift-subtract)
// on operand magnitudes over DATA_W RUN cycles, then applies a one-cycle sign fix.
// MTHI/MTLO write HI/LO directly from IDLE.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start, op     op request and op code (accepted only in IDLE)
//   a, b          operands (a also feeds MTHI/MTLO)
//   cancel        aborts an in-flight mul/div
//   busy, done    in-flight flag, one-cycle completion pulse
//   hi, lo        HI/LO registers
module muldiv_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned PW = 2 * DATA_W;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_is_div;
  logic              r_neg_q;     // negate product / quotient
  logic              r_neg_r;     // negate remainder (dividend was negative)
  logic [DATA_W-1:0] r_mag_a;     // multiplicand, or dividend shifting out / quotient shifting in
  logic [DATA_W-1:0] r_mag_b;     // divisor magnitude
  logic [PW-1:0]     r_acc;       // multiply accumulator, multiplier in the low half
  logic [DATA_W-1:0] r_rem;       // divide partial remainder

  logic              w_start_md;
  logic              w_mthi;
  logic              w_mtlo;
  logic              w_finish;

  // Operand magnitude and sign decode for the op being started
  logic              w_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_mag_a;
  logic [DATA_W-1:0] w_mag_b;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[DATA_W-1];
  assign w_b_neg  = w_signed & b[DATA_W-1];
  assign w_mag_a  = w_a_neg ? (~a + DATA_W'(1)) : a;
  assign w_mag_b  = w_b_neg ? (~b + DATA_W'(1)) : b;

  // One multiply step: conditionally add multiplicand to upper half, shift right with carry
  logic [DATA_W:0]   w_sum;
  logic [PW-1:0]     w_acc_nxt;

  assign w_sum     = {1'b0, r_acc[PW-1:DATA_W]} + (r_acc[0] ? {1'b0, r_mag_a} : (DATA_W+1)'(0));
  assign w_acc_nxt = {w_sum, r_acc[DATA_W-1:1]};

  // One restoring divide step on a DATA_W+1-bit partial remainder
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_qbit;

  assign w_shift = {r_rem, r_mag_a[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_mag_b};
  assign w_qbit  = ~w_diff[DATA_W];

  // Sign fix applied while in FIX
  logic [PW-1:0]     w_prod;
  logic [DATA_W-1:0] w_quo;
  logic [DATA_W-1:0] w_rmd;
  logic [DATA_W-1:0] w_res_hi;
  logic [DATA_W-1:0] w_res_lo;

  assign w_prod   = r_neg_q ? (~r_acc + PW'(1)) : r_acc;
  assign w_quo    = r_neg_q ? (~r_mag_a + DATA_W'(1)) : r_mag_a;
  assign w_rmd    = r_neg_r ? (~r_rem + DATA_W'(1)) : r_rem;
  assign w_res_hi = r_is_div ? w_rmd : w_prod[PW-1:DATA_W];
  assign w_res_lo = r_is_div ? w_quo : w_prod[DATA_W-1:0];

  // Next-state and op decode
  always_comb begin
    w_state_nxt = r_state;
    w_start_md  = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              w_start_md  = 1'b1;
              w_state_nxt = S_RUN;
            end
            OP_MTHI: w_mthi = 1'b1;
            OP_MTLO: w_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cancel) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_IDLE;
        w_finish    = ~cancel;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_finish;
      if (w_mthi) r_hi <= a;
      if (w_mtlo) r_lo <= a;
      if (w_finish) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
      if (w_start_md) begin
        r_cnt    <= '0;
        r_is_div <= op[1];
        // Divide by zero keeps an all-ones quotient regardless of dividend sign
        r_neg_q  <= (w_a_neg ^ w_b_neg) & ~(op[1] & (b == '0));
        r_neg_r  <= w_a_neg;
        r_mag_a  <= w_mag_a;
        r_mag_b  <= w_mag_b;
        r_acc    <= {DATA_W'(0), w_mag_b};
        r_rem    <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_is_div) begin
          r_rem   <= w_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
          r_mag_a <= {r_mag_a[DATA_W-2:0], w_qbit};
        end else begin
          r_acc   <= w_acc_nxt;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit with DATA_W=32.
module tb_muldiv_unit;

  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              cancel;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  int total;
  int bad;

  localparam int INJ_NONE   = 0;
  localparam int INJ_MTLO   = 1;
  localparam int INJ_CANCEL = 2;
  localparam int INJ_RST    = 3;

  muldiv_unit #(.DATA_W(DATA_W)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue a mul/div at edge 0, optionally inject an event sampled at edge inj_k,
  // and observe 37 edges: busy cycles, done pulses and the done edge, then HI/LO.
  task automatic run_md(input string tag, input logic [2:0] o,
                        input logic [31:0] ia, input logic [31:0] ib,
                        input int inj_k, input int inj_kind,
                        input int exp_busy, input int exp_dcnt, input int exp_dat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int busy_cnt;
    int done_cnt;
    int done_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    start = 1'b1;
    op    = o;
    a     = ia;
    b     = ib;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k <= 36; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        rst    = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      if (k == inj_k - 1) begin
        case (inj_kind)
          INJ_MTLO: begin
            start = 1'b1;
            op    = 3'b101;
            a     = 32'hDEAD;
          end
          INJ_CANCEL: cancel = 1'b1;
          INJ_RST:    rst    = 1'b1;
          default: ;
        endcase
      end
    end
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    chk({tag, "_done_count"},  64'(done_cnt), 64'(exp_dcnt));
    chk({tag, "_done_edge"},   64'(done_at),  64'(exp_dat));
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  // Single-edge MTHI/MTLO write, checked just after the edge
  task automatic mt_op(input string tag, input logic [2:0] o, input logic [31:0] ia,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1;
    op    = o;
    a     = ia;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_hi"},   64'(hi),   64'(exp_hi));
    chk({tag, "_lo"},   64'(lo),   64'(exp_lo));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 3'b000;
    a      = '0;
    b      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_hi",   64'(hi),   64'(0));
    chk("reset_lo",   64'(lo),   64'(0));
    rst = 1'b0;

    run_md("mult_7_m3", 3'b000, 32'd7, 32'hFFFFFFFD, 0, INJ_NONE,
           33, 1, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, INJ_NONE,
           33, 1, 33, 32'hFFFFFFFE, 32'h00000001);
    run_md("divu_100_7", 3'b011, 32'd100, 32'd7, 0, INJ_NONE,
           33, 1, 33, 32'd2, 32'd14);
    run_md("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 0, INJ_NONE,
           33, 1, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_min_m1", 3'b010, 32'h80000000, 32'hFFFFFFFF, 0, INJ_NONE,
           33, 1, 33, 32'h0, 32'h80000000);
    run_md("divu_by0", 3'b011, 32'h1234, 32'h0, 0, INJ_NONE,
           33, 1, 33, 32'h1234, 32'hFFFFFFFF);

    mt_op("mthi", 3'b100, 32'hAAAA0000, 32'hAAAA0000, 32'hFFFFFFFF);
    mt_op("mtlo", 3'b101, 32'h5555,     32'hAAAA0000, 32'h5555);

    run_md("mult_busy_start", 3'b000, 32'd3, 32'd4, 5, INJ_MTLO,
           33, 1, 33, 32'h0, 32'd12);

    mt_op("mthi2", 3'b100, 32'h1111, 32'h1111, 32'd12);
    mt_op("mtlo2", 3'b101, 32'h2222, 32'h1111, 32'h2222);

    run_md("mult_cancel", 3'b000, 32'd3, 32'd4, 10, INJ_CANCEL,
           10, 0, -1, 32'h1111, 32'h2222);
    run_md("mult_rst", 3'b000, 32'd3, 32'd4, 10, INJ_RST,
           10, 0, -1, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
